dsc_mul_nway: RTL and testbench

//  Parametrised N-input deterministic stochastic-computing (DSC) multiplier, serial clock-division scheme.

---
 rtl/dsc_pkg.sv | 21 ++
 rtl/dsc_sn_lane.sv | 35 +++
 rtl/dsc_mul_nway.sv | 113 +++++++++++
 tb/tb_dsc_mul_nway.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared types and width helpers for the deterministic stochastic-computing multiplier.
package dsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsc_state_t;

    localparam int DSC_DEF_WIDTH      = 6;
    localparam int DSC_DEF_NUM_INPUTS = 4;

    function automatic int prod_width(input int width, input int num_inputs);
        return width * num_inputs;
    endfunction

    function automatic int cyc_width(input int width, input int num_inputs);
        return width * num_inputs + 1;
    endfunction

endpackage

// File: rtl/dsc_sn_lane.sv
// One operand lane: latched operand plus its unary-stream counter.
// sn is the stream bit (op > ctr); wrap flags the counter rolling over this cycle.
module dsc_sn_lane
    import dsc_pkg::*;
#(
    parameter int WIDTH = DSC_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] op_in,
    output logic             sn,
    output logic             wrap,
    output logic [WIDTH-1:0] ctr
);

    logic [WIDTH-1:0] op_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= '0;
            ctr  <= '0;
        end else if (clr) begin
            op_q <= op_in;
            ctr  <= '0;
        end else if (inc) begin
            ctr <= ctr + WIDTH'(1);
        end
    end

    assign sn   = (op_q > ctr);
    assign wrap = inc & (&ctr);

endmodule

// File: rtl/dsc_mul_nway.sv
// N-input deterministic stochastic multiplier: cascaded lane counters, coincidence accumulator.
// Done rises K+1 cycles after start acceptance; en low freezes the run, start ignored while busy.
module dsc_mul_nway
    import dsc_pkg::*;
#(
    parameter int WIDTH      = DSC_DEF_WIDTH,
    parameter int NUM_INPUTS = DSC_DEF_NUM_INPUTS,
    parameter int EARLY_TERM = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          start,
    input  logic [WIDTH*NUM_INPUTS-1:0]   operands,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH*NUM_INPUTS-1:0]   z,
    output logic [WIDTH*NUM_INPUTS:0]     cycles
);

    localparam int PW = prod_width(WIDTH, NUM_INPUTS);
    localparam int CW = cyc_width(WIDTH, NUM_INPUTS);

    dsc_state_t state, state_nxt;

    logic [NUM_INPUTS-1:0] sn, wrap, inc;
    logic [PW-1:0]         ctr_all;
    logic                  carry_q;
    logic [CW-1:0]         cnt, limit_q, limit_nxt;
    logic [WIDTH-1:0]      op_top;
    logic                  any_zero;
    logic                  start_acc, at_limit, adv, hit;

    assign start_acc = start & (state != RUN);
    assign cnt       = {carry_q, ctr_all};
    assign at_limit  = (cnt == limit_q);
    assign adv       = (state == RUN) & en & ~at_limit;
    assign hit       = &sn;

    // Lane i only steps when every lane below it wraps in the same cycle.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        if (i == 0) begin : g_first
            assign inc[i] = adv;
        end else begin : g_rest
            assign inc[i] = wrap[i-1];
        end

        dsc_sn_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (start_acc),
            .inc   (inc[i]),
            .op_in (operands[i*WIDTH +: WIDTH]),
            .sn    (sn[i]),
            .wrap  (wrap[i]),
            .ctr   (ctr_all[i*WIDTH +: WIDTH])
        );
    end

    // Early stop: once the top lane passes its operand no stream bit of that lane is 1 again.
    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (operands[i*WIDTH +: WIDTH] == '0) any_zero = 1'b1;
        end
        op_top = operands[PW-1 -: WIDTH];
        if (EARLY_TERM != 0) begin
            limit_nxt = any_zero ? '0
                      : ({{(CW-WIDTH){1'b0}}, op_top} << (WIDTH*(NUM_INPUTS-1)));
        end else begin
            limit_nxt = {1'b1, {PW{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)           state_nxt = RUN;
            RUN:     if (en && at_limit)  state_nxt = DONE;
            DONE:    if (start)           state_nxt = RUN;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
            limit_q <= '0;
            z       <= '0;
            cycles  <= '0;
        end else if (start_acc) begin
            carry_q <= 1'b0;
            limit_q <= limit_nxt;
            z       <= '0;
            cycles  <= '0;
        end else if (adv) begin
            z      <= z + {{(PW-1){1'b0}}, hit};
            cycles <= cycles + CW'(1);
            if (wrap[NUM_INPUTS-1]) carry_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsc_mul_nway.sv
// Bench: instance A (W=3,N=3,early stop) and instance B (W=3,N=2,full run) against a product/latency model.
module tb_dsc_mul_nway;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_a = 1'b1, start_a = 1'b0;
    logic [8:0] ops_a = '0;
    logic       busy_a, done_a;
    logic [8:0] z_a;
    logic [9:0] cyc_a;
    logic       en_b = 1'b1, start_b = 1'b0;
    logic [5:0] ops_b = '0;
    logic       busy_b, done_b;
    logic [5:0] z_b;
    logic [6:0] cyc_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsc_mul_nway #(.WIDTH(3), .NUM_INPUTS(3), .EARLY_TERM(1)) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .start(start_a), .operands(ops_a),
        .busy(busy_a), .done(done_a), .z(z_a), .cycles(cyc_a)
    );

    dsc_mul_nway #(.WIDTH(3), .NUM_INPUTS(2), .EARLY_TERM(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .start(start_b), .operands(ops_b),
        .busy(busy_b), .done(done_b), .z(z_b), .cycles(cyc_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact product; early stop means the top lane's operand times the lower lanes' full span.
    function automatic void model_a(input logic [8:0] ops, output int prod, output int k);
        logic [8:0] v;
        int op_i;
        bit anyz;
        v = ops;
        prod = 1;
        anyz = 0;
        for (int i = 0; i < 3; i++) begin
            op_i = int'(v[i*3 +: 3]);
            prod = prod * op_i;
            if (op_i == 0) anyz = 1;
        end
        k = anyz ? 0 : int'(v[8:6]) * (2 ** (3 * 2));
    endfunction

    task automatic run_a(input string tag, input logic [8:0] ops, input int restart_at, input int pause_at);
        int prod, k, n, lat;
        model_a(ops, prod, k);
        lat = k + 1 + ((pause_at >= 0 && pause_at <= k) ? 10 : 0);
        ops_a = ops;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk({tag, ".busy_at_t0"}, 64'(busy_a), 64'd1);
        chk({tag, ".done_at_t0"}, 64'(done_a), 64'd0);
        ops_a = 9'($urandom);
        n = 0;
        while (!done_a && n < 2000) begin
            if (n == restart_at) start_a = 1'b1;
            if (n == pause_at) en_a = 1'b0;
            if (n == pause_at + 10) en_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            n++;
        end
        en_a = 1'b1;
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".z"}, 64'(z_a), 64'(prod));
        chk({tag, ".cycles"}, 64'(cyc_a), 64'(k));
        chk({tag, ".busy_done"}, 64'(busy_a), 64'd0);
    endtask

    task automatic run_b(input string tag, input logic [5:0] ops);
        int prod, n;
        prod = int'(ops[5:3]) * int'(ops[2:0]);
        ops_b = ops;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        ops_b = 6'($urandom);
        n = 0;
        while (!done_b && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'd65);
        chk({tag, ".z"}, 64'(z_b), 64'(prod));
        chk({tag, ".cycles"}, 64'(cyc_b), 64'd64);
    endtask

    initial begin
        int prod, k;
        logic [8:0] r_ops;
        logic [8:0] z_hold;

        #2 rst = 1'b0;
        #1;
        chk("rst.busy_a", 64'(busy_a), 64'd0);
        chk("rst.done_a", 64'(done_a), 64'd0);
        chk("rst.z_a", 64'(z_a), 64'd0);
        chk("rst.cyc_a", 64'(cyc_a), 64'd0);
        chk("rst.done_b", 64'(done_b), 64'd0);
        chk("rst.cyc_b", 64'(cyc_b), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_a("a_basic", {3'd5, 3'd3, 3'd2}, -1, -1);
        run_a("a_ones", {3'd7, 3'd7, 3'd7}, -1, -1);
        run_a("a_zero_lo", {3'd4, 3'd6, 3'd0}, -1, -1);
        run_a("a_zero_top", {3'd0, 3'd7, 3'd7}, -1, -1);

        z_hold = z_a;
        repeat (5) @(posedge clk);
        #1;
        chk("hold.done", 64'(done_a), 64'd1);
        chk("hold.z", 64'(z_a), 64'(z_hold));

        for (int i = 0; i < 20; i++) begin
            r_ops = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            run_a($sformatf("a_rand%0d", i), r_ops, -1, -1);
        end

        run_a("a_restart_ignored", {3'd6, 3'd5, 3'd4}, 20, -1);
        run_a("a_pause", {3'd6, 3'd5, 3'd4}, -1, 100);
        run_a("a_back2back", {3'd7, 3'd7, 3'd7}, -1, -1);

        model_a({3'd6, 3'd5, 3'd4}, prod, k);
        ops_a = {3'd6, 3'd5, 3'd4};
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (30) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_mid.busy", 64'(busy_a), 64'd0);
        chk("rst_mid.done", 64'(done_a), 64'd0);
        chk("rst_mid.z", 64'(z_a), 64'd0);
        chk("rst_mid.cycles", 64'(cyc_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid.idle_busy", 64'(busy_a), 64'd0);
        run_a("a_after_rst", {3'd6, 3'd5, 3'd4}, -1, -1);

        run_b("b_5x3", {3'd5, 3'd3});
        run_b("b_zero", {3'd0, 3'd6});
        run_b("b_ones", {3'd7, 3'd7});
        for (int i = 0; i < 4; i++) begin
            run_b($sformatf("b_rand%0d", i), 6'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
